// File: rtl/lcd_init_seq_if.sv
// Bundle between the LCD init sequencer, the top-level controller and the
// shared instruction writer. The sequencer side uses the master modport.
interface lcd_init_seq_if;
  logic       start;
  logic       instr_done;
  logic       instr_valid;
  logic [9:0] instr;
  logic       raw_e;
  logic [7:0] raw_data;
  logic       busy;
  logic       init_done;
  logic       err;

  modport master (
    input  start, instr_done,
    output instr_valid, instr, raw_e, raw_data, busy, init_done, err
  );

  modport slave (
    output start, instr_done,
    input  instr_valid, instr, raw_e, raw_data, busy, init_done, err
  );
endinterface

// File: rtl/lcd_init_seq.sv
// HD44780 power-on initialisation sequencer: raw E pulses for the wake-up
// writes, then configuration commands handed to the writer via valid/done.
module lcd_init_seq #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter bit          BUS_8BIT    = 1'b0,
  parameter logic [7:0]  FUNC_SET    = 8'h28,
  parameter logic [7:0]  ENTRY_MODE  = 8'h06,
  parameter logic [7:0]  DISP_CTRL   = 8'h0C,
  parameter int unsigned E_PULSE_CYC = 12,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter bit          AUTO_START  = 1'b1
) (
  input logic            clk,
  input logic            reset,
  lcd_init_seq_if.master bus
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] PWR_WAIT  = 4'd1;
  localparam logic [3:0] RAW1      = 4'd2;
  localparam logic [3:0] W4        = 4'd3;
  localparam logic [3:0] RAW2      = 4'd4;
  localparam logic [3:0] W100      = 4'd5;
  localparam logic [3:0] RAW3      = 4'd6;
  localparam logic [3:0] W40A      = 4'd7;
  localparam logic [3:0] RAW4      = 4'd8;
  localparam logic [3:0] W40B      = 4'd9;
  localparam logic [3:0] CMD_FUNC  = 4'd10;
  localparam logic [3:0] CMD_ENTRY = 4'd11;
  localparam logic [3:0] CMD_DISP  = 4'd12;
  localparam logic [3:0] CMD_CLR   = 4'd13;
  localparam logic [3:0] WCLR      = 4'd14;
  localparam logic [3:0] DONE      = 4'd15;

  // Timed states load N-1 so they last exactly N cycles; command states load
  // TIMEOUT_CYC so the writer gets TIMEOUT_CYC+1 cycles before giving up.
  localparam longint unsigned HZ   = 64'(CLK_HZ);
  localparam longint unsigned L15  = (HZ * 15 + 999) / 1000 - 1;
  localparam longint unsigned L4   = (HZ * 41 + 9999) / 10000 - 1;
  localparam longint unsigned L100 = (HZ + 9999) / 10000 - 1;
  localparam longint unsigned L40  = (HZ * 40 + 999999) / 1000000 - 1;
  localparam longint unsigned LCLR = (HZ * 164 + 99999) / 100000 - 1;
  localparam longint unsigned LE   = 64'(E_PULSE_CYC) - 1;
  localparam longint unsigned LTO  = 64'(TIMEOUT_CYC);

  function automatic longint unsigned max2(input longint unsigned a, input longint unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam longint unsigned MAXL =
    max2(max2(max2(L15, L4), max2(L100, L40)), max2(max2(LCLR, LE), LTO));
  localparam int CNT_W = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             gap_q, gap_d;
  logic [7:0]       cmd_byte;
  logic             is_raw, is_cmd;

  function automatic logic [CNT_W-1:0] load_for(input logic [3:0] st);
    case (st)
      PWR_WAIT:                                    return CNT_W'(L15);
      RAW1, RAW2, RAW3, RAW4:                      return CNT_W'(LE);
      W4:                                          return CNT_W'(L4);
      W100:                                        return CNT_W'(L100);
      W40A, W40B:                                  return CNT_W'(L40);
      CMD_FUNC, CMD_ENTRY, CMD_DISP, CMD_CLR:      return CNT_W'(LTO);
      WCLR:                                        return CNT_W'(LCLR);
      default:                                     return '0;
    endcase
  endfunction

  function automatic logic [3:0] next_of(input logic [3:0] st);
    case (st)
      PWR_WAIT:  return RAW1;
      RAW1:      return W4;
      W4:        return RAW2;
      RAW2:      return W100;
      W100:      return RAW3;
      RAW3:      return W40A;
      W40A:      return BUS_8BIT ? CMD_FUNC : RAW4;
      RAW4:      return W40B;
      W40B:      return CMD_FUNC;
      CMD_FUNC:  return CMD_ENTRY;
      CMD_ENTRY: return CMD_DISP;
      CMD_DISP:  return CMD_CLR;
      CMD_CLR:   return WCLR;
      WCLR:      return DONE;
      default:   return IDLE;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    err_d   = err_q;
    gap_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        cnt_d = cnt_q;
        if (bus.start) begin
          state_d = PWR_WAIT;
          err_d   = 1'b0;
        end
      end
      CMD_FUNC, CMD_ENTRY, CMD_DISP, CMD_CLR: begin
        // The gap cycle drops instr_valid between back-to-back commands.
        if (gap_q) begin
          cnt_d = cnt_q;
        end else if (bus.instr_done) begin
          state_d = next_of(state_q);
          gap_d   = (state_q != CMD_CLR);
        end else if (cnt_q == '0) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) state_d = next_of(state_q);
      end
    endcase
    if (state_d != state_q) cnt_d = load_for(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= AUTO_START ? PWR_WAIT : IDLE;
      cnt_q   <= AUTO_START ? CNT_W'(L15) : '0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    cmd_byte = 8'h00;
    case (state_q)
      CMD_FUNC:  cmd_byte = FUNC_SET;
      CMD_ENTRY: cmd_byte = ENTRY_MODE;
      CMD_DISP:  cmd_byte = DISP_CTRL;
      CMD_CLR:   cmd_byte = 8'h01;
      default:   cmd_byte = 8'h00;
    endcase
  end

  assign is_raw = (state_q == RAW1) || (state_q == RAW2) ||
                  (state_q == RAW3) || (state_q == RAW4);
  assign is_cmd = (state_q == CMD_FUNC) || (state_q == CMD_ENTRY) ||
                  (state_q == CMD_DISP) || (state_q == CMD_CLR);

  assign bus.raw_e       = is_raw;
  assign bus.raw_data    = (state_q == RAW4) ? 8'h02 :
                           is_raw ? (BUS_8BIT ? 8'h30 : 8'h03) : 8'h00;
  assign bus.instr_valid = is_cmd && !gap_q;
  assign bus.instr       = {2'b00, cmd_byte};
  assign bus.busy        = (state_q != IDLE) && (state_q != DONE);
  assign bus.init_done   = (state_q == DONE);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench: four sequencer configurations run side by side on one clock.
module tb_lcd_init_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst;
  logic [3:0] start_r;
  logic [3:0] done_r;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  lcd_init_seq_if if0 ();
  lcd_init_seq_if if1 ();
  lcd_init_seq_if if2 ();
  lcd_init_seq_if if3 ();

  lcd_init_seq #(.CLK_HZ(1000000), .BUS_8BIT(1'b0), .TIMEOUT_CYC(65535), .AUTO_START(1'b1))
    u0 (.clk(clk), .reset(rst[0]), .bus(if0));
  lcd_init_seq #(.CLK_HZ(1000000), .BUS_8BIT(1'b1), .TIMEOUT_CYC(65535), .AUTO_START(1'b1))
    u1 (.clk(clk), .reset(rst[1]), .bus(if1));
  lcd_init_seq #(.CLK_HZ(1000000), .BUS_8BIT(1'b0), .TIMEOUT_CYC(100), .AUTO_START(1'b1))
    u2 (.clk(clk), .reset(rst[2]), .bus(if2));
  lcd_init_seq #(.CLK_HZ(1000000), .BUS_8BIT(1'b0), .TIMEOUT_CYC(65535), .AUTO_START(1'b0))
    u3 (.clk(clk), .reset(rst[3]), .bus(if3));

  assign if0.start = start_r[0];  assign if0.instr_done = done_r[0];
  assign if1.start = start_r[1];  assign if1.instr_done = done_r[1];
  assign if2.start = start_r[2];  assign if2.instr_done = done_r[2];
  assign if3.start = start_r[3];  assign if3.instr_done = done_r[3];

  logic [3:0] raw_e_w, vld_w, idn_w, busy_w, err_w;
  logic [7:0] rd_w  [4];
  logic [9:0] ins_w [4];

  assign raw_e_w = {if3.raw_e, if2.raw_e, if1.raw_e, if0.raw_e};
  assign vld_w   = {if3.instr_valid, if2.instr_valid, if1.instr_valid, if0.instr_valid};
  assign idn_w   = {if3.init_done, if2.init_done, if1.init_done, if0.init_done};
  assign busy_w  = {if3.busy, if2.busy, if1.busy, if0.busy};
  assign err_w   = {if3.err, if2.err, if1.err, if0.err};
  assign rd_w[0] = if0.raw_data;  assign ins_w[0] = if0.instr;
  assign rd_w[1] = if1.raw_data;  assign ins_w[1] = if1.instr;
  assign rd_w[2] = if2.raw_data;  assign ins_w[2] = if2.instr;
  assign rd_w[3] = if3.raw_data;  assign ins_w[3] = if3.instr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic sel(input int i, input int w);
    case (w)
      0:       return raw_e_w[i];
      1:       return vld_w[i];
      2:       return idn_w[i];
      default: return busy_w[i];
    endcase
  endfunction

  // Counts falling edges until the chosen output reaches lvl, capped at budget.
  task automatic wait_sig(input int i, input int w, input logic lvl, input int budget, output int n);
    n = 0;
    while (sel(i, w) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse(input int i, input int gap, input logic [7:0] rd, input string tag);
    int n;
    wait_sig(i, 0, 1'b1, gap + 64, n);
    check_eq({tag, "_gap"}, 32'(n), 32'(gap));
    check_eq({tag, "_data"}, 32'(rd_w[i]), 32'(rd));
    wait_sig(i, 0, 1'b0, 64, n);
    check_eq({tag, "_width"}, 32'(n), 32'd12);
  endtask

  // Writer model: acks on the third edge after instr_valid rises (u2 never acks).
  logic [3:0] ack_en = 4'b1011;
  int         wcnt    [4];
  int         n_ack   [4];
  int         ack_cyc [4];
  logic [9:0] exp_ins [4] = '{10'h028, 10'h006, 10'h00C, 10'h001};

  initial begin
    done_r = '0;
    for (int i = 0; i < 4; i++) begin
      wcnt[i] = 0; n_ack[i] = 0; ack_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (done_r[i]) begin
          done_r[i] = 1'b0;
          wcnt[i]   = 0;
          check_eq("vld_after_ack", 32'(vld_w[i]), 32'd0);
        end else if (vld_w[i] && ack_en[i]) begin
          wcnt[i]++;
          if (wcnt[i] == 3) begin
            done_r[i]  = 1'b1;
            ack_cyc[i] = cyc + 1;
            check_eq("instr", 32'(ins_w[i]),
                     (n_ack[i] < 4) ? 32'(exp_ins[n_ack[i][1:0]]) : 32'h3FF);
            n_ack[i]++;
          end
        end else begin
          wcnt[i] = 0;
        end
      end
    end
  end

  task automatic scen_a();
    int n;
    pulse(0, 15000, 8'h03, "a_p1");
    pulse(0, 4100, 8'h03, "a_p2");
    pulse(0, 100, 8'h03, "a_p3");
    pulse(0, 40, 8'h02, "a_p4");
    wait_sig(0, 1, 1'b1, 200, n);
    check_eq("a_cmd_entry", 32'(n), 32'd40);
    wait_sig(0, 2, 1'b1, 5000, n);
    check_eq("a_clr_wait", 32'(cyc - ack_cyc[0]), 32'd1640);
    check_eq("a_n_ack", 32'(n_ack[0]), 32'd4);
    check_eq("a_busy_done", 32'(busy_w[0]), 32'd0);
    check_eq("a_err_done", 32'(err_w[0]), 32'd0);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    check_eq("a_restart_idn", 32'(idn_w[0]), 32'd0);
    check_eq("a_restart_busy", 32'(busy_w[0]), 32'd1);
    pulse(0, 15000, 8'h03, "a_r1");
    wait_sig(0, 0, 1'b1, 5000, n);
    check_eq("a_r2_gap", 32'(n), 32'd4100);
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    #1;
    check_eq("a_rst_raw_e", 32'(raw_e_w[0]), 32'd0);
    check_eq("a_rst_raw_data", 32'(rd_w[0]), 32'd0);
    check_eq("a_rst_busy", 32'(busy_w[0]), 32'd1);
    check_eq("a_rst_valid", 32'(vld_w[0]), 32'd0);
    check_eq("a_rst_instr", 32'(ins_w[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    pulse(0, 15000, 8'h03, "a_post_rst");
  endtask

  task automatic scen_b();
    int n;
    pulse(1, 15000, 8'h30, "b_p1");
    pulse(1, 4100, 8'h30, "b_p2");
    pulse(1, 100, 8'h30, "b_p3");
    wait_sig(1, 1, 1'b1, 200, n);
    check_eq("b_cmd_entry", 32'(n), 32'd40);
    wait_sig(1, 2, 1'b1, 3000, n);
    check_eq("b_init_done", 32'(idn_w[1]), 32'd1);
    check_eq("b_n_ack", 32'(n_ack[1]), 32'd4);
    check_eq("b_err", 32'(err_w[1]), 32'd0);
  endtask

  task automatic scen_c();
    int n;
    wait_sig(2, 1, 1'b1, 25000, n);
    check_eq("c_cmd_at", 32'(n), 32'd19328);
    check_eq("c_instr", 32'(ins_w[2]), 32'h028);
    wait_sig(2, 1, 1'b0, 200, n);
    check_eq("c_timeout_len", 32'(n), 32'd101);
    check_eq("c_err", 32'(err_w[2]), 32'd1);
    check_eq("c_init_done", 32'(idn_w[2]), 32'd1);
    check_eq("c_busy", 32'(busy_w[2]), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("c_err_sticky", 32'(err_w[2]), 32'd1);
    start_r[2] = 1'b1;
    @(negedge clk);
    start_r[2] = 1'b0;
    check_eq("c_err_clr", 32'(err_w[2]), 32'd0);
    check_eq("c_idn_clr", 32'(idn_w[2]), 32'd0);
    check_eq("c_busy_restart", 32'(busy_w[2]), 32'd1);
    pulse(2, 15000, 8'h03, "c_r1");
  endtask

  task automatic scen_d();
    int cnt;
    int n;
    int m;
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busy_w[3] || raw_e_w[3]) cnt++;
    end
    check_eq("d_idle_quiet", 32'(cnt), 32'd0);
    start_r[3] = 1'b1;
    @(negedge clk);
    start_r[3] = 1'b0;
    check_eq("d_busy_start", 32'(busy_w[3]), 32'd1);
    pulse(3, 15000, 8'h03, "d_p1");
    n = 0;
    repeat (50) begin
      @(negedge clk);
      n++;
      if (n == 10) start_r[3] = 1'b1;
      if (n == 11) start_r[3] = 1'b0;
    end
    wait_sig(3, 0, 1'b1, 5000, m);
    check_eq("d_w4_gap", 32'(n + m), 32'd4100);
    wait_sig(3, 0, 1'b0, 64, m);
    pulse(3, 100, 8'h03, "d_p3");
    pulse(3, 40, 8'h02, "d_p4");
    wait_sig(3, 1, 1'b1, 200, n);
    check_eq("d_cmd_entry", 32'(n), 32'd40);
  endtask

  initial begin
    rst     = 4'hF;
    start_r = 4'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_valid", 32'(vld_w[i]), 32'd0);
      check_eq("rst_instr", 32'(ins_w[i]), 32'd0);
      check_eq("rst_raw_e", 32'(raw_e_w[i]), 32'd0);
      check_eq("rst_raw_data", 32'(rd_w[i]), 32'd0);
      check_eq("rst_init_done", 32'(idn_w[i]), 32'd0);
      check_eq("rst_err", 32'(err_w[i]), 32'd0);
      check_eq("rst_busy", 32'(busy_w[i]), 32'(i != 3));
    end
    rst = 4'h0;
    fork
      scen_a();
      scen_b();
      scen_c();
      scen_d();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
